// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and result bus for seq_restoring_divider.
// Optional macro SEQ_DIV_OVF_EN adds the overflow flag.
`timescale 1ns/1ps
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
`ifdef SEQ_DIV_OVF_EN
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Signed (truncating) or unsigned operands; reports divide-by-zero.
// Optional macro SEQ_DIV_OVF_EN adds an overflow flag for MOST_NEG / -1.
`timescale 1ns/1ps
module seq_restoring_divider #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_flag_q, dbz_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
`ifdef SEQ_DIV_OVF_EN
  logic             ovf_flag_q, ovf_flag_d;
  logic             ovf_q, ovf_d;
`endif

  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   diff_c;

  // Two's-complement magnitude in signed mode; MOST_NEG reads as 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    if ((SIGNED != 0) && v[WIDTH-1]) return -v;
    return v;
  endfunction

  // Trial subtraction of one restoring step.
  always_comb begin
    shifted_c = (p_q << 1) | (WIDTH+1)'(a_q[WIDTH-1]);
    diff_c    = shifted_c - {1'b0, b_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    dbz_flag_d = dbz_flag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
`ifdef SEQ_DIV_OVF_EN
    ovf_flag_d = ovf_flag_q;
    ovf_d      = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d     = 1'b1;
          dbz_flag_d = (bus.divisor == '0);
          // Divide-by-zero keeps the raw dividend in A for the remainder output.
          a_d        = dbz_flag_d ? bus.dividend : mag(bus.dividend);
          b_d        = mag(bus.divisor);
          p_d        = '0;
          cnt_d      = CW'(WIDTH);
          neg_quo_d  = (SIGNED != 0) && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_rem_d  = (SIGNED != 0) && bus.dividend[WIDTH-1];
`ifdef SEQ_DIV_OVF_EN
          ovf_flag_d = (SIGNED != 0) && (bus.dividend == MOST_NEG) && (bus.divisor == '1);
`endif
          state_d    = dbz_flag_d ? FIX : CALC;
        end
      end
      CALC: begin
        if (diff_c[WIDTH]) begin
          p_d = shifted_c;
          a_d = {a_q[WIDTH-2:0], 1'b0};
        end else begin
          p_d = diff_c;
          a_d = {a_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (dbz_flag_q) begin
          quo_d = '1;
          rem_d = a_q;
        end else begin
          quo_d = neg_quo_q ? -a_q : a_q;
          rem_d = neg_rem_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        end
        dbz_d   = dbz_flag_q;
`ifdef SEQ_DIV_OVF_EN
        ovf_d   = ovf_flag_q;
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
`ifdef SEQ_DIV_OVF_EN
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      dbz_flag_q <= dbz_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
`ifdef SEQ_DIV_OVF_EN
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
`ifdef SEQ_DIV_OVF_EN
  assign bus.overflow    = ovf_q;
`endif

endmodule
